// File: rtl/rom_weight_sequencer.sv
// rom_weight_sequencer: walks a neuron weight ROM (1-cycle synchronous read)
// and streams the weights to the MAC over a valid/ready interface.
// A 2-entry skid FIFO absorbs the ROM read latency so that backpressure on
// ready_i never loses or duplicates a word.
// Optional build macro: ROM_WRITE_EN adds a PROG state and ROM write ports
// so the weights can be loaded before a read pass.
//
// Handshake: a weight transfers on a rising edge where valid_o & ready_i;
// valid_o and weight_o stay stable while valid_o=1 and ready_i=0, and
// valid_o never depends combinationally on ready_i.
module rom_weight_sequencer #(
    parameter int depth     = 3,
    parameter int width     = 8,
    parameter int N_WEIGHTS = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    output logic             ready_o,
    input  logic             abort_i,
    output logic [depth-1:0] rom_addr_o,
    input  logic [width-1:0] rom_data_i,
    output logic [width-1:0] weight_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             last_o,
    output logic             done_o
`ifdef ROM_WRITE_EN
    ,
    input  logic             prog_valid_i,
    input  logic [width-1:0] prog_data_i,
    output logic [width-1:0] rom_wdata_o,
    output logic             rom_wen_o
`endif
);

    localparam int            LAST     = N_WEIGHTS - 1;
    localparam logic [depth:0] N_CNT    = N_WEIGHTS[depth:0];
    localparam logic [depth:0] LAST_CNT = LAST[depth:0];

    typedef enum logic [1:0] {IDLE, RUN, DONE, PROG} state_t;

    state_t state;
    state_t state_nxt;

    // issue_cnt is one bit wider than the address so that N_WEIGHTS = 2**depth
    // can be represented without the final address wrapping to 0
    logic [depth:0]   issue_cnt;
    logic [depth:0]   recv_cnt;
    logic             pend;
    logic [width-1:0] fifo_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       occ;
    logic [2:0]       fill;
    logic             pop;
    logic             issue;
    logic             last_xfer;
    logic             flush;

    assign pop       = valid_o & ready_i;
    assign fill      = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
    assign flush     = (state == RUN) && abort_i;
    assign issue     = (state == RUN) && !abort_i && (issue_cnt < N_CNT) && (fill < 3'd2);
    assign last_xfer = (state == RUN) && pop && (recv_cnt == LAST_CNT);

`ifdef ROM_WRITE_EN
    logic [depth:0] wr_cnt;
    logic           wr_fire;

    assign wr_fire = (state == PROG) && prog_valid_i && !abort_i;
`endif

    // state register
    always_ff @(posedge clk_i) begin
        if (!reset_i) state <= IDLE;
        else          state <= state_nxt;
    end

    // next-state logic; abort beats a same-cycle last transfer
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_i) state_nxt = RUN;
`ifdef ROM_WRITE_EN
                else if (prog_valid_i) state_nxt = PROG;
`endif
            end
            RUN: begin
                if (abort_i)        state_nxt = IDLE;
                else if (last_xfer) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            PROG: begin
`ifdef ROM_WRITE_EN
                if (abort_i)                              state_nxt = IDLE;
                else if (prog_valid_i && wr_cnt == LAST_CNT) state_nxt = DONE;
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // outputs decoded from state and counters
    always_comb begin
        ready_o    = reset_i && (state == IDLE);
        done_o     = (state == DONE);
        valid_o    = (occ != 2'd0);
        weight_o   = valid_o ? fifo_mem[rd_ptr] : '0;
        last_o     = valid_o && (recv_cnt == LAST_CNT);
        rom_addr_o = (issue_cnt >= N_CNT) ? LAST_CNT[depth-1:0] : issue_cnt[depth-1:0];
`ifdef ROM_WRITE_EN
        rom_wen_o   = wr_fire;
        rom_wdata_o = wr_fire ? prog_data_i : '0;
        if (state == PROG) rom_addr_o = wr_cnt[depth-1:0];
`endif
    end

    // read issue / receive counters and the pending-read flag
    always_ff @(posedge clk_i) begin
        if (!reset_i || state != RUN || abort_i) begin
            issue_cnt <= '0;
            recv_cnt  <= '0;
            pend      <= 1'b0;
        end else begin
            if (issue) issue_cnt <= issue_cnt + 1'b1;
            if (pop)   recv_cnt  <= recv_cnt + 1'b1;
            pend <= issue;
        end
    end

    // 2-entry skid FIFO: capture ROM data one cycle after each issued read
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            occ         <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (pend) begin
                fifo_mem[wr_ptr] <= rom_data_i;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, pend} - {1'b0, pop};
        end
    end

`ifdef ROM_WRITE_EN
    // write counter for the programming pass
    always_ff @(posedge clk_i) begin
        if (!reset_i || state != PROG) wr_cnt <= '0;
        else if (wr_fire)              wr_cnt <= wr_cnt + 1'b1;
    end
`endif

    // parameter legality and FIFO overflow guard
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            assert (N_WEIGHTS >= 1 && N_WEIGHTS <= (1 << depth));
            assert (!(pend && !pop && occ == 2'd2));
        end
    end

endmodule
